cnt_timer_arbiter: RTL and testbench
====================================

CNT_TIMER_ARBITER -- requirements
Module: cnt_timer_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the counter.
REQ-002 SHALL have parameter WIDTH, default 8, counter and terminal-count width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester request level, held until done or abort.
REQ-006 SHALL have port n_count  input  N_REQ*WIDTH  per-requester terminal count, slice i = bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt  output  N_REQ  one-hot grant, all-zero when idle.
REQ-008 SHALL have port done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port busy  output  1  high whenever the counter is owned.
REQ-010 SHALL have port q  output  WIDTH  current shared count value.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 In IDLE with any req bit high, SHALL select one requester round-robin, searching upward from ptr and wrapping at N_REQ-1 to 0.
REQ-013 On selection, SHALL latch the winner index and its n_count slice; later n_count changes SHALL NOT affect the run.
REQ-014 For latched n >= 1, SHALL enter RUN with q=1 in the cycle after req is sampled.
REQ-015 In RUN, SHALL increment q by 1 per cycle; when q equals latched n, SHALL enter DONE the next cycle.
REQ-016 For latched n = 0, SHALL go from IDLE directly to DONE with q=0.
REQ-017 In DONE, SHALL assert done[idx] for exactly one cycle, hold q, then return to IDLE.
REQ-018 gnt[idx] and busy SHALL be high in RUN and DONE, low in IDLE.
REQ-019 q SHALL be 0 in IDLE.
REQ-020 Leaving DONE or aborting, SHALL set ptr = idx+1 modulo N_REQ.
REQ-021 Latency for n >= 1: req sampled in cycle 0 -> gnt and q=1 in cycle 1 -> q=n in cycle n -> done in cycle n+1 -> IDLE in cycle n+2.
REQ-022 If req[idx] falls in RUN, SHALL abort to IDLE next cycle with no done pulse.
REQ-023 req[idx] falling in DONE SHALL NOT suppress the done pulse.
REQ-024 Requests arriving in RUN or DONE SHALL wait; arbitration SHALL occur only in IDLE.
REQ-025 A requester still holding req after done SHALL be re-eligible at lowest priority via ptr.
REQ-026 q SHALL never exceed latched n; n = 2^WIDTH-1 SHALL count to all-ones without wrap.
REQ-027 done and gnt SHALL be registered outputs, glitch-free.

Reset
REQ-028 On reset, SHALL set state=IDLE, ptr=0, q=0, gnt=0, done=0, busy=0, latched index=0, latched n=0.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL abort without a done pulse; reset SHALL take priority over all other events.

Structure
REQ-030 State encodings and N_REQ/WIDTH defaults SHALL live in shared package cnt_timer_arb_pkg.
REQ-031 The round-robin selection SHALL be a combinational sub-module rr_pick, with inputs req and ptr and outputs a one-hot winner and a valid flag.
REQ-032 Counter, FSM, and latches SHALL reside in cnt_timer_arbiter.

Verification
REQ-033 SHALL verify a single run: req=0001, n0=3 -> gnt=0001 in cycles 1-4, q=1,2,3,3, done=0001 in cycle 4 only, IDLE in cycle 5.
REQ-034 SHALL verify round-robin order: req=1111 held constantly with all n=1 -> grants 0001, 0010, 0100, 1000, 0001 in order.
REQ-035 SHALL verify zero count: req=0100, n2=0 -> done=0100 in cycle 1, q=0 throughout, no RUN state.
REQ-036 SHALL verify abort: req=0010, n1=10, req dropped at q=4 -> IDLE next cycle, done stays 0, next grant searches from requester 2.
REQ-037 SHALL verify reset mid-run: reset at q=5 of n=200 -> next cycle q=0, gnt=0, busy=0, no done pulse, ptr=0.
REQ-038 SHALL verify maximum count: n=255 -> q reaches 255 without wrap and done fires in cycle 256.

Source files
------------

// File: rtl/cnt_timer_arb_pkg.sv
// Shared types and defaults for the counter-timer arbiter.
package cnt_timer_arb_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, wrapping.
module rr_pick
  import cnt_timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] k;
  logic             found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    k      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = IDX_W'((32'(ptr) + i) % N_REQ);
      if (!found && req[k]) begin
        winner[k] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/cnt_timer_arbiter.sv
// Shared up-counter timer granted round-robin to N_REQ requesters;
// each grant counts 1..n and pulses done to the owner.
module cnt_timer_arbiter
  import cnt_timer_arb_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*WIDTH-1:0] n_count,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic [WIDTH-1:0]   q
);

  localparam int unsigned IDX_W = idx_width(N_REQ);

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, ptr_inc;
  logic [IDX_W-1:0] idx, idx_n, win_idx;
  logic [WIDTH-1:0] n_lat, n_n, win_n, q_n;
  logic [N_REQ-1:0] gnt_n, done_n, winner;
  logic             win_valid;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .valid  (win_valid)
  );

  assign ptr_inc = (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
  assign busy    = (state != IDLE);

  // gnt/done/q are computed here and registered below so the outputs are flop-driven.
  always_comb begin
    state_n = state;
    q_n     = q;
    gnt_n   = gnt;
    done_n  = '0;
    idx_n   = idx;
    n_n     = n_lat;
    ptr_n   = ptr;
    win_idx = '0;
    win_n   = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        win_idx = IDX_W'(i);
        win_n   = n_count[i*WIDTH +: WIDTH];
      end
    end
    case (state)
      IDLE: begin
        if (win_valid) begin
          idx_n = win_idx;
          n_n   = win_n;
          gnt_n = winner;
          if (win_n == '0) begin
            state_n = DONE;
            q_n     = '0;
            done_n  = winner;
          end else begin
            state_n = RUN;
            q_n     = WIDTH'(1);
          end
        end
      end
      RUN: begin
        if (!req[idx]) begin
          state_n = IDLE;
          q_n     = '0;
          gnt_n   = '0;
          ptr_n   = ptr_inc;
        end else if (q == n_lat) begin
          state_n = DONE;
          done_n  = gnt;
        end else begin
          q_n = q + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        q_n     = '0;
        gnt_n   = '0;
        ptr_n   = ptr_inc;
      end
      default: begin
        state_n = IDLE;
        q_n     = '0;
        gnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      q     <= '0;
      gnt   <= '0;
      done  <= '0;
      idx   <= '0;
      n_lat <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      q     <= q_n;
      gnt   <= gnt_n;
      done  <= done_n;
      idx   <= idx_n;
      n_lat <= n_n;
    end
  end

endmodule

// File: tb/tb_cnt_timer_arbiter.sv
// Directed scoreboard bench for cnt_timer_arbiter (N_REQ=4, WIDTH=8).
module tb_cnt_timer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] n_count;
  logic [3:0]  gnt, done;
  logic        busy;
  logic [7:0]  q;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] done;
    logic [7:0] q;
    logic       busy;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  cnt_timer_arbiter #(
    .N_REQ (4),
    .WIDTH (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .n_count (n_count),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy),
    .q       (q)
  );

  always #5 clk = ~clk;

  // Push the expected post-edge outputs, advance one clock, pop and compare.
  task automatic tick(input logic [3:0] eg, input logic [3:0] ed,
                      input logic [7:0] eq, input logic eb, input string tag);
    exp_t e;
    sb.push_back('{gnt: eg, done: ed, q: eq, busy: eb, tag: tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests++;
    assert (gnt === e.gnt) else begin
      fails++;
      $error("FAIL %s gnt: got %b expected %b", e.tag, gnt, e.gnt);
    end
    tests++;
    assert (done === e.done) else begin
      fails++;
      $error("FAIL %s done: got %b expected %b", e.tag, done, e.done);
    end
    tests++;
    assert (q === e.q) else begin
      fails++;
      $error("FAIL %s q: got %0d expected %0d", e.tag, q, e.q);
    end
    tests++;
    assert (busy === e.busy) else begin
      fails++;
      $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
    end
  endtask

  initial begin
    logic [3:0] rr_order [5];
    rr_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    reset   = 1'b1;
    req     = '0;
    n_count = '0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "reset0");
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "reset1");
    reset = 1'b0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "idle");

    // Round-robin with all requests held, n=1 each; ptr starts at 0.
    req     = 4'b1111;
    n_count = {8'd1, 8'd1, 8'd1, 8'd1};
    for (int g = 0; g < 5; g++) begin
      tick(rr_order[g], 4'b0000, 8'd1, 1'b1, "rr_run");
      tick(rr_order[g], rr_order[g], 8'd1, 1'b1, "rr_done");
      if (g == 4) req = '0;
      tick(4'b0000, 4'b0000, 8'd0, 1'b0, "rr_idle");
    end

    // Single run n0=3; n_count change after latch must not matter.
    req     = 4'b0001;
    n_count = {8'd1, 8'd1, 8'd1, 8'd3};
    tick(4'b0001, 4'b0000, 8'd1, 1'b1, "run_c1");
    n_count = {8'd1, 8'd1, 8'd1, 8'd7};
    tick(4'b0001, 4'b0000, 8'd2, 1'b1, "run_c2");
    tick(4'b0001, 4'b0000, 8'd3, 1'b1, "run_c3");
    tick(4'b0001, 4'b0001, 8'd3, 1'b1, "run_c4_done");
    req = '0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "run_c5_idle");
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "run_c6_idle");

    // Zero count on requester 2: straight to DONE.
    req     = 4'b0100;
    n_count = {8'd1, 8'd0, 8'd1, 8'd1};
    tick(4'b0100, 4'b0100, 8'd0, 1'b1, "zero_done");
    req = '0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "zero_idle");

    // Abort requester 1 at q=4 (ptr is 3, search 3,0,1).
    req     = 4'b0010;
    n_count = {8'd1, 8'd1, 8'd10, 8'd1};
    for (int i = 1; i <= 4; i++) tick(4'b0010, 4'b0000, 8'(i), 1'b1, "abort_run");
    req = '0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "abort_idle");
    // ptr must now be 2: with 0,1,2 requesting, 2 wins.
    req     = 4'b0111;
    n_count = {8'd1, 8'd1, 8'd1, 8'd1};
    tick(4'b0100, 4'b0000, 8'd1, 1'b1, "after_abort_run");
    tick(4'b0100, 4'b0100, 8'd1, 1'b1, "after_abort_done");
    req = '0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "after_abort_idle");

    // Reset at q=5 of n=200 (ptr was 3 before reset).
    req     = 4'b0010;
    n_count = {8'd1, 8'd1, 8'd200, 8'd1};
    for (int i = 1; i <= 5; i++) tick(4'b0010, 4'b0000, 8'(i), 1'b1, "rst_run");
    reset = 1'b1;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "rst_abort");
    reset   = 1'b0;
    req     = 4'b1010;
    n_count = {8'd1, 8'd1, 8'd1, 8'd1};
    tick(4'b0010, 4'b0000, 8'd1, 1'b1, "rst_ptr0_run");
    tick(4'b0010, 4'b0010, 8'd1, 1'b1, "rst_ptr0_done");
    req = '0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "rst_ptr0_idle");

    // Maximum count n=255 on requester 0 (ptr 2, search 2,3,0).
    req     = 4'b0001;
    n_count = {8'd1, 8'd1, 8'd1, 8'd255};
    for (int i = 1; i <= 255; i++) tick(4'b0001, 4'b0000, 8'(i), 1'b1, "max_run");
    tick(4'b0001, 4'b0001, 8'd255, 1'b1, "max_done");
    req = '0;
    tick(4'b0000, 4'b0000, 8'd0, 1'b0, "max_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
